// File: rtl/aes_pkg.sv
// Shared AES byte arithmetic, column/state types and the engine FSM encoding.
// GF(2^8) products are built from xtime chains only, so synthesis sees pure XOR trees.
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [31:0]      col_t;
   // Element [3] holds column 0 (bits 127:96), matching the bus layout.
   typedef logic [3:0][31:0] state_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mulB(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mulD(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mulE(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Input-state and result handshakes of the MixColumns engine.
interface mix_columns_engine_if;
   import aes_pkg::*;

   logic   s_valid;
   logic   s_ready;
   logic   s_inv;
   state_t s_state;
   logic   m_valid;
   logic   m_ready;
   state_t m_state;

   modport master (output s_valid, s_inv, s_state, m_ready,
                   input  s_ready, m_valid, m_state);
   modport slave  (input  s_valid, s_inv, s_state, m_ready,
                   output s_ready, m_valid, m_state);

endinterface

// File: rtl/mix_col_word.sv
// One AES column through MixColumns (inv=0) or InvMixColumns (inv=1), purely combinational.
module mix_col_word
   import aes_pkg::*;
(
   input  col_t a,
   input  logic inv,
   output col_t y
);

   logic [7:0] b [4];

   always_comb begin
      for (int r = 0; r < 4; r++) b[r] = a[31-8*r -: 8];
      y = '0;
      for (int r = 0; r < 4; r++) begin
         if (inv)
            y[31-8*r -: 8] = gf_mulE(b[r])        ^ gf_mulB(b[2'(r+1)]) ^
                             gf_mulD(b[2'(r+2)])  ^ gf_mul9(b[2'(r+3)]);
         else
            y[31-8*r -: 8] = gf_mul2(b[r])        ^ gf_mul3(b[2'(r+1)]) ^
                             b[2'(r+2)]           ^ b[2'(r+3)];
      end
   end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative (Inv)MixColumns over a 128-bit AES state, COLS_PER_CYCLE columns per clock.
// One block in flight: IDLE accepts, BUSY mixes, DONE holds the result until taken.
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   mix_columns_engine_if.slave  bus,
   output logic                 busy
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // With 4 columns per cycle the step wraps to 0, so every iteration is the last.
   localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

   fsm_t       state_q, state_d;
   state_t     work_q, res_q;
   logic       inv_q;
   logic [1:0] cnt_q, cnt_nxt;
   logic       last;

   logic [1:0] idx     [COLS_PER_CYCLE];
   col_t       col_in  [COLS_PER_CYCLE];
   col_t       col_out [COLS_PER_CYCLE];

   assign cnt_nxt = cnt_q + STEP;
   assign last    = (cnt_nxt == 2'd0);

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign idx[g]    = cnt_q + 2'(g);
      assign col_in[g] = work_q[~idx[g]];
      mix_col_word u_mix (
         .a   (col_in[g]),
         .inv (inv_q),
         .y   (col_out[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.s_valid) state_d = BUSY;
         BUSY:    if (last)        state_d = DONE;
         DONE:    if (bus.m_ready) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.s_ready = 1'b0;
      bus.m_valid = 1'b0;
      busy        = 1'b0;
      case (state_q)
         IDLE:    bus.s_ready = 1'b1;
         BUSY:    busy        = 1'b1;
         DONE: begin
            bus.m_valid = 1'b1;
            busy        = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work_q <= '0;
         res_q  <= '0;
         inv_q  <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         case (state_q)
            IDLE: if (bus.s_valid) begin
               work_q <= bus.s_state;
               inv_q  <= bus.s_inv;
               cnt_q  <= 2'd0;
            end
            BUSY: begin
               for (int g = 0; g < COLS_PER_CYCLE; g++) res_q[~idx[g]] <= col_out[g];
               cnt_q <= cnt_nxt;
            end
            default: ;
         endcase
      end
   end

   assign bus.m_state = res_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: one DUT per COLS_PER_CYCLE (1, 2, 4), known vectors,
// handshake corner sequences and a randomized stream against a generic GF(2^8) model.
module tb_mix_columns_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]        sv, si, mr;
   logic [2:0][127:0] ss;
   logic [2:0]        sr, mv, bw;
   logic [2:0][127:0] ms;

   int n_tests = 0;
   int n_fail  = 0;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mix_columns_engine_if bus ();
      assign bus.s_valid = sv[gi];
      assign bus.s_inv   = si[gi];
      assign bus.s_state = ss[gi];
      assign bus.m_ready = mr[gi];
      assign sr[gi]      = bus.s_ready;
      assign mv[gi]      = bus.m_valid;
      assign ms[gi]      = bus.m_state;
      mix_columns_engine #(.COLS_PER_CYCLE(1 << gi)) dut (
         .clk  (clk),
         .rst  (rst),
         .bus  (bus),
         .busy (bw[gi])
      );
   end

   // Reference: textbook shift-and-add GF(2^8) product and the per-row coefficient rule.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
      logic [7:0]   cf [4];
      logic [7:0]   a  [4];
      logic [7:0]   o;
      logic [127:0] res = '0;
      if (inv) begin cf[0] = 8'h0E; cf[1] = 8'h0B; cf[2] = 8'h0D; cf[3] = 8'h09; end
      else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127 - 32*c - 8*r -: 8];
         for (int r = 0; r < 4; r++) begin
            o = 8'h00;
            for (int k = 0; k < 4; k++) o ^= gmul(cf[k], a[(r + k) % 4]);
            res[127 - 32*c - 8*r -: 8] = o;
         end
      end
      return res;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for the DUT", nm);
   endtask

   // Called and returns at a negedge. One full block: accept, latency, result, handoff.
   task automatic run_block(input int k, input logic inv, input logic [127:0] din,
                            input logic [127:0] exp, input string nm);
      int lat, w;
      w = 0;
      while (!sr[k] && w < 50) begin @(negedge clk); w++; end
      if (!sr[k]) begin timeout({nm, " s_ready"}); return; end
      sv[k] = 1'b1; si[k] = inv; ss[k] = din;
      @(posedge clk); @(negedge clk);
      sv[k] = 1'b0;
      lat = 0;
      while (!mv[k] && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
      chki({nm, " latency"}, lat, 4 >> k);
      chk ({nm, " m_state"}, ms[k], exp);
      chkb({nm, " busy"}, bw[k], 1'b1);
      mr[k] = 1'b1;
      @(posedge clk); @(negedge clk);
      mr[k] = 1'b0;
      chkb({nm, " m_valid after handoff"}, mv[k], 1'b0);
      chkb({nm, " s_ready after handoff"}, sr[k], 1'b1);
   endtask

   // Free-running upstream/downstream with random gaps and stalls; every accepted
   // state is queued and compared against the model when its result is taken.
   task automatic stream(input int k, input int nblk);
      logic [128:0] q[$];
      logic [128:0] e;
      logic         p_acc, p_hand;
      logic [127:0] p_ms;
      int           got, cyc;
      got = 0; cyc = 0;
      p_acc = 1'b0; p_hand = 1'b0; p_ms = '0;
      sv[k] = 1'b0; mr[k] = 1'b0;
      while (got < nblk && cyc < 40 * nblk) begin
         if (p_acc) q.push_back({si[k], ss[k]});
         if (p_hand) begin
            if (q.size() == 0) timeout("stream result without accepted state");
            else begin
               e = q.pop_front();
               chk($sformatf("stream cpc=%0d blk=%0d", 1 << k, got), p_ms, mix_model(e[127:0], e[128]));
            end
            got++;
         end
         if (p_acc || !sv[k]) begin
            if ($urandom_range(3) != 0) begin
               sv[k] = 1'b1;
               si[k] = 1'($urandom_range(1));
               ss[k] = {$urandom, $urandom, $urandom, $urandom};
            end else sv[k] = 1'b0;
         end
         mr[k]  = ($urandom_range(2) != 0);
         p_acc  = sv[k] && sr[k];
         p_hand = mv[k] && mr[k];
         p_ms   = ms[k];
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      sv[k] = 1'b0; mr[k] = 1'b0;
      if (got < nblk) timeout($sformatf("stream cpc=%0d", 1 << k));
   endtask

   typedef struct {
      int           k;
      logic         inv;
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   localparam logic [127:0] V_A  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V_AM = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V_B  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
   localparam logic [127:0] V_BM = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
   localparam logic [127:0] V_F  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam logic [127:0] V_FM = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

   initial begin
      vec_t         tbl [7];
      logic [127:0] x;
      logic         seen;

      tbl[0] = '{0, 1'b0, V_A,  V_AM};
      tbl[1] = '{2, 1'b1, V_AM, V_A };
      tbl[2] = '{1, 1'b0, V_B,  V_BM};
      tbl[3] = '{1, 1'b1, V_BM, V_B };
      tbl[4] = '{1, 1'b0, V_F,  V_FM};
      tbl[5] = '{0, 1'b1, V_FM, V_F };
      tbl[6] = '{2, 1'b0, V_F,  V_FM};

      sv = '0; si = '0; mr = '0; ss = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chkb($sformatf("reset s_ready cpc=%0d", 1 << k), sr[k], 1'b1);
         chkb($sformatf("reset m_valid cpc=%0d", 1 << k), mv[k], 1'b0);
         chkb($sformatf("reset busy cpc=%0d",    1 << k), bw[k], 1'b0);
         chk ($sformatf("reset m_state cpc=%0d", 1 << k), ms[k], '0);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         run_block(tbl[i].k, tbl[i].inv, tbl[i].din, tbl[i].dout, $sformatf("vec%0d", i));

      // Stalled result, ignored pulse, then release with s_valid already waiting.
      sv[0] = 1'b1; si[0] = 1'b0; ss[0] = V_A;
      @(posedge clk); @(negedge clk);
      sv[0] = 1'b0;
      for (int w = 0; w < 20 && !mv[0]; w++) begin @(posedge clk); @(negedge clk); end
      for (int i = 0; i < 10; i++) begin
         chk ($sformatf("stall m_state %0d", i), ms[0], V_AM);
         chkb($sformatf("stall s_ready %0d", i), sr[0], 1'b0);
         chkb($sformatf("stall m_valid %0d", i), mv[0], 1'b1);
         if (i == 3) begin sv[0] = 1'b1; si[0] = 1'b1; ss[0] = {4{32'h11223344}}; end
         if (i == 4) sv[0] = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      sv[0] = 1'b1; si[0] = 1'b0; ss[0] = V_F; mr[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      mr[0] = 1'b0;
      chkb("release m_valid", mv[0], 1'b0);
      chkb("release s_ready (not accepted on handoff)", sr[0], 1'b1);
      run_block(0, 1'b0, V_F, V_FM, "after release");

      // Reset during the second BUSY cycle aborts the block.
      sv[0] = 1'b1; si[0] = 1'b0; ss[0] = V_A;
      @(posedge clk); @(negedge clk);
      sv[0] = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chkb("abort s_ready", sr[0], 1'b1);
      chkb("abort m_valid", mv[0], 1'b0);
      chkb("abort busy",    bw[0], 1'b0);
      chk ("abort m_state", ms[0], '0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); @(negedge clk);
         seen |= mv[0];
      end
      chkb("abort no result", seen, 1'b0);

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 20; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            run_block(k, 1'b0, x, mix_model(x, 1'b0), $sformatf("rt fwd cpc=%0d", 1 << k));
            run_block(k, 1'b1, mix_model(x, 1'b0), x, $sformatf("rt inv cpc=%0d", 1 << k));
         end
      end

      for (int k = 0; k < 3; k++) stream(k, 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
